bsg_front_side_bus_hop_out_no_fc: RTL and testbench
===================================================

# bsg_front_side_bus_hop_out_no_fc

Output-side hop of the front-side bus ring without flow control: merges through-traffic arriving from the upstream hop-in stage with packets injected by the local node, and registers the result onto the next ring segment. Bus through-traffic always has priority and is never stalled. Local packets are staged in a small FIFO with a valid/ready handshake and drain into idle bus slots. The block sits directly downstream of the hop-in stage, taking its "continue on ring" valid and data, and drives the next hop-in.

## Interface
Parameters:
- width_p, 32, bus/packet width in bits
- local_els_p, 4, local FIFO depth; power of two, ≥2

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- bus_v_i  in  1  through-traffic valid from upstream hop-in (its ring-continue valid)
- bus_data_i  in  width_p  through-traffic data
- local_v_i  in  1  local node offers a packet
- local_data_i  in  width_p  local packet
- local_ready_o  out  1  FIFO can accept; transfer when local_v_i & local_ready_o
- v_o  out  1  registered valid to next ring segment
- data_o  out  width_p  registered data to next ring segment
- blocked_cycles_o  out  16  only with BSG_FSB_HOP_OUT_STATS_EN (see Configuration)

## Operation
- Local FIFO: local_els_p entries, read/write pointers of log2(local_els_p) bits wrapping naturally, occupancy count of log2(local_els_p)+1 bits.
- local_ready_o = (count != local_els_p) & ~reset_i; depends only on registered state, never on same-cycle dequeue. A full FIFO does not accept even if it dequeues in that cycle.
- Enqueue when local_v_i & local_ready_o; local_data_i written at write pointer.
- Arbitration each cycle, fixed priority:
  - bus_v_i=1: send bus_data_i; FIFO not dequeued.
  - bus_v_i=0, FIFO non-empty: send head entry; dequeue.
  - otherwise: send nothing.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Enqueue into empty FIFO is not visible to the arbiter until the next cycle (no bypass).
- Output register: v_o <= send; data_o loads only when send=1, otherwise holds its previous value.
- No packet is ever dropped or duplicated; bus ordering preserved; local ordering preserved (FIFO).

## Timing
- Reset values: v_o=0, count=0, pointers=0, local_ready_o=0 during reset, 1 in the first cycle after. data_o and FIFO storage are not reset.
- Reset mid-operation flushes the FIFO; pending local packets are discarded; v_o=0 the cycle after reset is sampled; enqueue ignored during reset.
- Bus latency: bus_v_i in cycle N → v_o/data_o in cycle N+1.
- Local latency, idle bus: accepted in cycle N → dequeued in N+1 → on v_o in N+2.
- Sustained bus_v_i=1 blocks local traffic indefinitely; local_ready_o falls once local_els_p packets are queued.
- Max local throughput: one packet per cycle when bus idle.

## Configuration
- BSG_FSB_HOP_OUT_STATS_EN defined: blocked_cycles_o port exists; 16-bit counter, reset to 0, increments each cycle FIFO is non-empty and bus_v_i=1; saturates at 16'hFFFF; cleared only by reset.
- Undefined: port and counter absent; datapath behaviour identical.

## Test plan
- Reset: hold reset_i 2 cycles with bus_v_i=1, local_v_i=1 → v_o=0 cycle after each reset cycle, local_ready_o=0 during reset, no FIFO enqueue (first post-reset idle-bus cycle sends nothing local).
- Bus pass-through: bus_v_i=1, bus_data_i=32'hA5A5_0001 in cycle 5 → v_o=1, data_o=32'hA5A5_0001 in cycle 6; next cycle idle → v_o=0, data_o holds.
- Local drain: bus idle, local packets 0x10,0x11,0x12 in cycles 3,4,5 → v_o=1 with 0x10,0x11,0x12 in cycles 5,6,7.
- Priority/fill: bus_v_i=1 continuously, local_v_i=1 with 0x20..0x25 → only 0x20..0x23 accepted, local_ready_o=0 after 4th; drop bus_v_i → 0x20..0x23 emitted in order on consecutive cycles, then 0x24,0x25 after acceptance.
- Full with simultaneous events: FIFO full, bus idle, local_v_i=1 → that cycle no enqueue (ready=0), one dequeue; next cycle ready=1 and enqueue proceeds; count never exceeds 4.
- Stats (macro on): FIFO non-empty, bus_v_i=1 for 70000 cycles → blocked_cycles_o=16'hFFFF, stays; reset → 0.

Source files
------------

// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// Ring hop-out: merges upstream through-traffic with local packets from a small FIFO into a registered output.
// Latency: bus 1 cycle, local 2 cycles on an idle bus; bus never stalls, local_ready_o drops only when the FIFO is full.
// Optional stall statistics under BSG_FSB_HOP_OUT_STATS_EN (adds blocked_cycles_o).
module bsg_front_side_bus_hop_out_no_fc #(
  parameter int width_p     = 32,
  parameter int local_els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               bus_v_i,
  input  logic [width_p-1:0] bus_data_i,
  input  logic               local_v_i,
  input  logic [width_p-1:0] local_data_i,
  output logic               local_ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o
`ifdef BSG_FSB_HOP_OUT_STATS_EN
  , output logic [15:0]      blocked_cycles_o
`endif
);

  localparam int ptr_w_lp = $clog2(local_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(local_els_p);

  logic [width_p-1:0]  mem_r [local_els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                fifo_nonempty;
  logic                enq, deq, send;
  logic [width_p-1:0]  send_data;

  // Readiness comes only from registered occupancy, so a full FIFO refuses even while draining.
  assign local_ready_o = (count_r != full_cnt_lp) & ~reset_i;
  assign fifo_nonempty = (count_r != '0);

  always_comb begin
    enq       = local_v_i & local_ready_o;
    deq       = ~bus_v_i & fifo_nonempty;
    send      = bus_v_i | deq;
    send_data = bus_v_i ? bus_data_i : mem_r[rptr_r];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + 1'b1;
      if (deq) rptr_r <= rptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= local_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) v_o <= 1'b0;
    else         v_o <= send;
  end

  // data_o is deliberately not reset; it holds the last sent word when idle.
  always_ff @(posedge clk_i) begin
    if (send & ~reset_i) data_o <= send_data;
  end

`ifdef BSG_FSB_HOP_OUT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)
      blocked_cycles_o <= '0;
    else if (fifo_nonempty & bus_v_i & (blocked_cycles_o != 16'hFFFF))
      blocked_cycles_o <= blocked_cycles_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// Scoreboard bench for the hop-out stage: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_bsg_front_side_bus_hop_out_no_fc;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        bus_v_i = 1'b0;
  logic [31:0] bus_data_i = '0;
  logic        local_v_i = 1'b0;
  logic [31:0] local_data_i = '0;
  logic        local_ready_o;
  logic        v_o;
  logic [31:0] data_o;
`ifdef BSG_FSB_HOP_OUT_STATS_EN
  logic [15:0] blocked_cycles_o;
`endif

  bsg_front_side_bus_hop_out_no_fc #(.width_p(32), .local_els_p(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .bus_v_i      (bus_v_i),
    .bus_data_i   (bus_data_i),
    .local_v_i    (local_v_i),
    .local_data_i (local_data_i),
    .local_ready_o(local_ready_o),
    .v_o          (v_o),
    .data_o       (data_o)
`ifdef BSG_FSB_HOP_OUT_STATS_EN
    , .blocked_cycles_o(blocked_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  bit          done = 1'b0;
  logic [31:0] sb[$];   // expected output words, in order
  logic [31:0] mq[$];   // model of the local FIFO contents
  logic [31:0] lq[$];   // local packets waiting to be offered

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus; the reference queue model predicts readiness and the next output word.
  task automatic step(input logic rst, input logic bv, input logic [31:0] bd);
    logic rdy_exp;
    @(posedge clk); #1;
    reset_i      = rst;
    bus_v_i      = bv;
    bus_data_i   = bd;
    local_v_i    = (lq.size() != 0);
    local_data_i = local_v_i ? lq[0] : 32'h0;
    #1;
    rdy_exp = !rst && (mq.size() != 4);
    chk("local_ready", {31'b0, local_ready_o}, {31'b0, rdy_exp});
    if (rst) begin
      mq.delete();
    end else begin
      if (bv) sb.push_back(bd);
      else if (mq.size() != 0) sb.push_back(mq.pop_front());
      if (local_v_i && rdy_exp) mq.push_back(lq.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!done && v_o === 1'b1) begin
      if (sb.size() == 0) chk("spurious_v_o", {31'b0, v_o}, 32'h0);
      else chk("data_o", data_o, sb.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with bus and local both active: nothing may be enqueued or emitted.
    lq.push_back(32'hBEEF_0000);
    step(1, 1, 32'hDEAD_0001);
    step(1, 1, 32'hDEAD_0002);
    step(0, 0, 0);
    @(negedge clk); chk("rst_v_o_a", {31'b0, v_o}, 32'h0);
    step(0, 0, 0);
    @(negedge clk); chk("rst_v_o_b", {31'b0, v_o}, 32'h0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Bus pass-through, then idle: data_o must hold.
    step(0, 1, 32'hA5A5_0001);
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    chk("idle_v_o", {31'b0, v_o}, 32'h0);
    chk("hold_data_o", data_o, 32'hA5A5_0001);

    // Local drain on idle bus, back to back.
    lq.push_back(32'h10); lq.push_back(32'h11); lq.push_back(32'h12);
    repeat (6) step(0, 0, 0);

    // Bus priority fills the FIFO; then bus drops and everything drains in order.
    for (int i = 0; i < 6; i++) lq.push_back(32'h20 + i);
    for (int i = 0; i < 8; i++) step(0, 1, 32'hB000_0000 + i);
    chk("fill_count", mq.size(), 32'd4);
    repeat (10) step(0, 0, 0);

    // Bus interleaved with local traffic.
    lq.push_back(32'h40); lq.push_back(32'h41);
    step(0, 0, 0);
    step(0, 1, 32'hC000_0001);
    step(0, 0, 0);
    step(0, 1, 32'hC000_0002);
    repeat (4) step(0, 0, 0);

    // Mid-operation reset discards queued local packets.
    lq.push_back(32'h30); lq.push_back(32'h31);
    repeat (3) step(0, 1, 32'hD000_0000);
    step(1, 1, 32'hD000_0001);
    repeat (4) step(0, 0, 0);

`ifdef BSG_FSB_HOP_OUT_STATS_EN
    lq.push_back(32'h50);
    for (int i = 0; i < 70000; i++) step(0, 1, 32'hE000_0000 + i);
    @(negedge clk); chk("stats_sat", {16'h0, blocked_cycles_o}, 32'h0000_FFFF);
    repeat (5) step(0, 1, 32'hE100_0000);
    @(negedge clk); chk("stats_hold", {16'h0, blocked_cycles_o}, 32'h0000_FFFF);
    step(1, 0, 0);
    step(0, 0, 0);
    @(negedge clk); chk("stats_rst", {16'h0, blocked_cycles_o}, 32'h0);
    repeat (3) step(0, 0, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
